// File: rtl/proc_control_unit_pkg.sv
// Shared types and constants for the processor control unit: state encoding,
// opcode values, ALU select codes and the opcode-to-execute-state decode.
package processor_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Map an opcode to the first execute state; unknown opcodes behave as NOOP.
  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      OP_NOOP:  decode_op = S_NOOP;
      OP_STORE: decode_op = S_STORE;
      OP_LOAD:  decode_op = S_LOAD_A;
      OP_ADD:   decode_op = S_ADD;
      OP_SUB:   decode_op = S_SUB;
      OP_HALT:  decode_op = S_HALT;
      default:  decode_op = S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Control-unit bus: instruction register in, datapath/memory controls and
// debug state out. master = control unit, slave = datapath side.
interface proc_control_unit_if;

  logic [15:0] IR;
  logic        PC_Clr;
  logic        PC_Up;
  logic        IR_Ld;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;
  logic [3:0]  NextState;

  modport master (
    input  IR,
    output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, NextState
  );

  modport slave (
    output IR,
    input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, NextState
  );

endinterface

// File: rtl/proc_control_unit_ctrl_wait_counter.sv
// Wait-state down-counter: loaded with LAT-1 when a waiting state is entered,
// counts down to zero and holds there; zero_o marks the last cycle of a wait.
module ctrl_wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load takes priority, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/proc_control_unit.sv
// Moore control FSM for the 16-bit processor: fetch/decode/execute sequencing
// with wait states for instruction and data memory latency.
module proc_control_unit
  import processor_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  proc_control_unit_if.master bus
);

  localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] IMEM_LD = CNT_W'(IMEM_LAT - 1);
  localparam logic [CNT_W-1:0] DMEM_LD = CNT_W'(DMEM_LAT - 1);

  state_t           state_q;
  state_t           state_d;
  state_t           next_state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  ctrl_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // State register; reset forces INIT from any state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; IR is only consulted in DECODE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (cnt_zero) state_d = S_DECODE;
      S_DECODE: state_d = decode_op(bus.IR[15:12]);
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: if (cnt_zero) state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Reset-aware next state, plus counter load on entry to a waiting state.
  always_comb begin
    next_state = Reset ? S_INIT : state_d;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    if (next_state != state_q) begin
      if (next_state == S_FETCH) begin
        cnt_load = 1'b1;
        cnt_val  = IMEM_LD;
      end else if (next_state == S_LOAD_A) begin
        cnt_load = 1'b1;
        cnt_val  = DMEM_LD;
      end
    end
  end

  // Moore output decode from the current state, IR fields and wait count.
  always_comb begin
    bus.PC_Clr     = 1'b0;
    bus.PC_Up      = 1'b0;
    bus.IR_Ld      = 1'b0;
    bus.D_Addr     = 8'h00;
    bus.D_Wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_Addr  = 4'h0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_Addr = 4'h0;
    bus.RF_Rb_Addr = 4'h0;
    bus.ALU_s0     = ALU_PASS;
    case (state_q)
      S_INIT: bus.PC_Clr = 1'b1;
      S_FETCH: begin
        if (cnt_zero) begin
          bus.IR_Ld = 1'b1;
          bus.PC_Up = 1'b1;
        end
      end
      S_LOAD_A: bus.D_Addr = bus.IR[11:4];
      S_LOAD_B: begin
        bus.D_Addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_Addr = bus.IR[3:0];
        bus.RF_W_en   = 1'b1;
      end
      S_STORE: begin
        bus.D_Addr     = bus.IR[7:0];
        bus.RF_Ra_Addr = bus.IR[11:8];
        bus.D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_Addr = bus.IR[11:8];
        bus.RF_Rb_Addr = bus.IR[7:4];
        bus.RF_W_Addr  = bus.IR[3:0];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign bus.State     = state_q;
  assign bus.NextState = next_state;

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit (IMEM_LAT=2, DMEM_LAT=3) with a small PC/IR
// model feeding a directed program; expected output events are queued up
// front and a negedge monitor pops and compares each observed event.
module tb_proc_control_unit;
  import processor_pkg::*;

  typedef struct packed {
    state_t      st;
    state_t      nx;
    logic        pc_clr;
    logic        pc_up;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
  } ev_t;

  logic Clk;
  logic Reset;
  proc_control_unit_if bus();

  proc_control_unit #(
    .IMEM_LAT (2),
    .DMEM_LAT (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory and program counter model driven by the DUT strobes.
  logic [15:0] imem [8];
  logic [2:0]  pc;
  always @(posedge Clk) begin
    if (bus.PC_Clr) pc <= 3'd0;
    else if (bus.PC_Up) pc <= pc + 3'd1;
    if (bus.IR_Ld) bus.IR <= imem[pc];
  end

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_ev     = 0;
  logic mon_en   = 1'b0;
  logic fin_req  = 1'b0;
  logic fin_done = 1'b0;

  function automatic ev_t mk(state_t st, state_t nx, logic pc_clr, logic pc_up,
                             logic ir_ld, logic [7:0] d_addr, logic d_wr,
                             logic rf_s, logic [3:0] w_addr, logic w_en,
                             logic [3:0] ra, logic [3:0] rb, logic [2:0] alu);
    ev_t e;
    e.st = st; e.nx = nx; e.pc_clr = pc_clr; e.pc_up = pc_up; e.ir_ld = ir_ld;
    e.d_addr = d_addr; e.d_wr = d_wr; e.rf_s = rf_s; e.w_addr = w_addr;
    e.w_en = w_en; e.ra = ra; e.rb = rb; e.alu = alu;
    return e;
  endfunction

  task automatic exp_init(input state_t nx);
    exp_q.push_back(mk(S_INIT, nx, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
  endtask
  task automatic exp_fetch();
    exp_q.push_back(mk(S_FETCH, S_DECODE, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
  endtask
  task automatic exp_alu(input state_t st, input state_t nx, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rd, input logic [2:0] alu);
    exp_q.push_back(mk(st, nx, 0, 0, 0, 8'h00, 0, 0, rd, 1, ra, rb, alu));
  endtask
  task automatic exp_loada(input logic [7:0] a, input state_t nx);
    exp_q.push_back(mk(S_LOAD_A, nx, 0, 0, 0, a, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
  endtask
  task automatic exp_loadb(input logic [7:0] a, input logic [3:0] rd);
    exp_q.push_back(mk(S_LOAD_B, S_FETCH, 0, 0, 0, a, 0, 1, rd, 1, 4'h0, 4'h0, 3'b000));
  endtask
  task automatic exp_store(input logic [3:0] ra, input logic [7:0] a);
    exp_q.push_back(mk(S_STORE, S_FETCH, 0, 0, 0, a, 1, 0, 4'h0, 0, ra, 4'h0, 3'b000));
  endtask
  task automatic exp_halt(input state_t nx);
    exp_q.push_back(mk(S_HALT, nx, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
  endtask

  // Monitor: any strobe, LOAD_A or HALT cycle is an event checked against the queue.
  always @(negedge Clk) begin
    ev_t act;
    ev_t exp;
    act = mk(state_t'(bus.State), state_t'(bus.NextState), bus.PC_Clr, bus.PC_Up,
             bus.IR_Ld, bus.D_Addr, bus.D_Wr, bus.RF_s, bus.RF_W_Addr, bus.RF_W_en,
             bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.ALU_s0);
    if (mon_en && (bus.PC_Clr || bus.PC_Up || bus.IR_Ld || bus.D_Wr || bus.RF_W_en ||
                   bus.State == S_LOAD_A || bus.State == S_HALT)) begin
      n_checks = n_checks + 1;
      n_ev     = n_ev + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_event%0d got=%h want=none", n_ev, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_err = n_err + 1;
          $display("FAIL event%0d got=%h want=%h (st %0d/%0d nx %0d/%0d)", n_ev, act, exp,
                   act.st, exp.st, act.nx, exp.nx);
        end
      end
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      n_checks = n_checks + 1;
      if (exp_q.size() != 0) begin
        n_err = n_err + 1;
        $display("FAIL missing_events got=%0d want=0", exp_q.size());
      end
    end
  end

  initial begin
    imem[0] = 16'h3124;  // ADD R4 = R1 + R2
    imem[1] = 16'h21A3;  // LOAD R3 <- D[1A]
    imem[2] = 16'h1507;  // STORE R5 -> D[07]
    imem[3] = 16'h4321;  // SUB R1 = R3 - R2
    imem[4] = 16'h0000;  // NOOP
    imem[5] = 16'h7000;  // undefined opcode, runs as NOOP
    imem[6] = 16'h5000;  // HALT
    imem[7] = 16'h0000;

    // Phase A: reset, then run the program into HALT.
    exp_init(S_INIT);
    exp_init(S_FETCH);
    exp_fetch();
    exp_alu(S_ADD, S_FETCH, 4'd1, 4'd2, 4'd4, ALU_ADD);
    exp_fetch();
    exp_loada(8'h1A, S_LOAD_A);
    exp_loada(8'h1A, S_LOAD_A);
    exp_loada(8'h1A, S_LOAD_B);
    exp_loadb(8'h1A, 4'd3);
    exp_fetch();
    exp_store(4'd5, 8'h07);
    exp_fetch();
    exp_alu(S_SUB, S_FETCH, 4'd3, 4'd2, 4'd1, ALU_SUB);
    exp_fetch();
    exp_fetch();
    exp_fetch();
    for (int i = 0; i < 19; i++) exp_halt(S_HALT);
    exp_halt(S_INIT);
    exp_init(S_FETCH);
    // Phase B: reset during ADD, then reset during LOAD_A.
    exp_fetch();
    exp_alu(S_ADD, S_INIT, 4'd1, 4'd2, 4'd4, ALU_ADD);
    exp_init(S_FETCH);
    exp_fetch();
    exp_alu(S_ADD, S_FETCH, 4'd1, 4'd2, 4'd4, ALU_ADD);
    exp_fetch();
    exp_loada(8'h1A, S_LOAD_A);
    exp_loada(8'h1A, S_INIT);
    exp_init(S_FETCH);
    exp_fetch();
    exp_alu(S_ADD, S_FETCH, 4'd1, 4'd2, 4'd4, ALU_ADD);

    Reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;                 // cycle 2
    repeat (50) @(posedge Clk);
    #1 Reset = 1'b1;                 // cycle 52, last HALT cycle
    @(posedge Clk);
    #1 Reset = 1'b0;                 // cycle 53, INIT
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;                 // cycle 57, ADD
    @(posedge Clk);
    #1 Reset = 1'b0;                 // cycle 58, INIT
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;                 // cycle 67, second LOAD_A
    @(posedge Clk);
    #1 Reset = 1'b0;                 // cycle 68, INIT
    repeat (5) @(posedge Clk);
    #1;                              // cycle 73, after the final ADD
    mon_en  = 1'b0;
    fin_req = 1'b1;
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
